// File: rtl/periph_bus_pkg.sv
// Shared constants and types for peripheral bus bridges: region map,
// bridge FSM states, slave selection and the default slave timeout.
package periph_bus_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

  localparam logic [31:0] TMR_BASE  = 32'h0200_0000;
  localparam logic [31:0] TMR_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] UART_BASE = 32'h1000_0000;
  localparam logic [31:0] UART_MASK = 32'hFFFF_F000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } bridge_state_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_TMR,
    SEL_UART
  } slave_sel_e;

  function automatic logic region_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/periph_addr_decode.sv
// Combinational address decoder: maps a CPU address to a slave select
// and flags word alignment. Shared by all bridges on this bus.
module periph_addr_decode
  import periph_bus_pkg::*;
(
  input  logic [31:0] addr_i,
  output slave_sel_e  sel_o,
  output logic        aligned_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives sel_o; no latch.
    sel_o = SEL_NONE;
    if (region_hit(addr_i, TMR_BASE, TMR_MASK)) begin
      sel_o = SEL_TMR;
    end else if (region_hit(addr_i, UART_BASE, UART_MASK)) begin
      sel_o = SEL_UART;
    end
  end

  assign aligned_o = (addr_i[1:0] == 2'b00);

endmodule

// File: rtl/periph_bus_bridge.sv
// Single-outstanding CPU-to-peripheral bridge with timer and UART slaves,
// per-access slave timeout and error responses for bad addresses.
module periph_bus_bridge
  import periph_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,

  output logic        tmr_req,
  output logic [31:0] tmr_addr,
  output logic [31:0] tmr_wdata,
  output logic        tmr_we,
  input  logic [31:0] tmr_rdata,
  input  logic        tmr_ready,

  output logic        uart_req,
  output logic [31:0] uart_addr,
  output logic [31:0] uart_wdata,
  output logic        uart_we,
  input  logic [31:0] uart_rdata,
  input  logic        uart_ready
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  slave_sel_e    dec_sel;
  logic          dec_aligned;

  bridge_state_e state_q;
  slave_sel_e    sel_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [CNT_W-1:0] cnt_q;
  logic          tmr_req_q;
  logic          uart_req_q;
  logic          rvalid_q;
  logic          err_q;
  logic [31:0]   rdata_q;

  logic          sel_ready;
  logic [31:0]   sel_rdata;

  periph_addr_decode u_decode (
    .addr_i    (cpu_addr),
    .sel_o     (dec_sel),
    .aligned_o (dec_aligned)
  );

  assign sel_ready = (sel_q == SEL_TMR) ? tmr_ready : uart_ready;
  assign sel_rdata = (sel_q == SEL_TMR) ? tmr_rdata : uart_rdata;

  assign cpu_gnt = (state_q == ST_IDLE) && cpu_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      tmr_req_q  <= 1'b0;
      uart_req_q <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        ST_IDLE: begin
          rvalid_q <= 1'b0;
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            we_q    <= cpu_we;
            sel_q   <= dec_sel;
            if (dec_sel != SEL_NONE && dec_aligned) begin
              state_q    <= ST_ACCESS;
              cnt_q      <= '0;
              tmr_req_q  <= (dec_sel == SEL_TMR);
              uart_req_q <= (dec_sel == SEL_UART);
            end else begin
              // Bad address: answer directly, never touching a slave.
              state_q  <= ST_RESP;
              rvalid_q <= 1'b1;
              err_q    <= 1'b1;
              rdata_q  <= '0;
            end
          end
        end

        ST_ACCESS: begin
          if (sel_ready) begin
            state_q    <= ST_RESP;
            rvalid_q   <= 1'b1;
            err_q      <= 1'b0;
            rdata_q    <= we_q ? '0 : sel_rdata;
            tmr_req_q  <= 1'b0;
            uart_req_q <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            // This is the TIMEOUT_CYCLES-th cycle without ready: give up.
            state_q    <= ST_RESP;
            rvalid_q   <= 1'b1;
            err_q      <= 1'b1;
            rdata_q    <= '0;
            tmr_req_q  <= 1'b0;
            uart_req_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_RESP: begin
          rvalid_q <= 1'b0;
          state_q  <= ST_IDLE;
        end

        default: begin
          state_q    <= ST_IDLE;
          rvalid_q   <= 1'b0;
          tmr_req_q  <= 1'b0;
          uart_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_err    = err_q;

  assign tmr_req    = tmr_req_q;
  assign tmr_addr   = addr_q;
  assign tmr_wdata  = wdata_q;
  assign tmr_we     = we_q;

  assign uart_req   = uart_req_q;
  assign uart_addr  = addr_q;
  assign uart_wdata = wdata_q;
  assign uart_we    = we_q;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Scoreboard bench for periph_bus_bridge: responses are predicted at grant
// time and matched (data, error, cycle) when cpu_rvalid pulses.
module tb_periph_bus_bridge;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        tmr_req;
  logic [31:0] tmr_addr;
  logic [31:0] tmr_wdata;
  logic        tmr_we;
  logic [31:0] tmr_rdata;
  logic        tmr_ready;
  logic        uart_req;
  logic [31:0] uart_addr;
  logic [31:0] uart_wdata;
  logic        uart_we;
  logic [31:0] uart_rdata;
  logic        uart_ready;

  resp_t       sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          tmr_req_cnt = 0;
  int          uart_req_cnt = 0;
  int          bus_bad = 0;
  logic [31:0] cur_addr = '0;
  logic [31:0] cur_wdata = '0;
  logic        cur_we = 1'b0;

  periph_bus_bridge dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .tmr_req    (tmr_req),
    .tmr_addr   (tmr_addr),
    .tmr_wdata  (tmr_wdata),
    .tmr_we     (tmr_we),
    .tmr_rdata  (tmr_rdata),
    .tmr_ready  (tmr_ready),
    .uart_req   (uart_req),
    .uart_addr  (uart_addr),
    .uart_wdata (uart_wdata),
    .uart_we    (uart_we),
    .uart_rdata (uart_rdata),
    .uart_ready (uart_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slave-side observation plus response scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (tmr_req) begin
      tmr_req_cnt++;
      if (tmr_addr !== cur_addr || tmr_wdata !== cur_wdata || tmr_we !== cur_we) bus_bad++;
    end
    if (uart_req) begin
      uart_req_cnt++;
      if (uart_addr !== cur_addr || uart_wdata !== cur_wdata || uart_we !== cur_we) bus_bad++;
    end
    if (tmr_req && uart_req) bus_bad++;
    if (cpu_rvalid) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        resp_t r;
        r = sb.pop_front();
        check("rdata", cpu_rdata, r.rdata);
        check("err", {31'b0, cpu_err}, {31'b0, r.err});
        check("rvalid_cycle", cyc, r.cyc);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic w,
                       input logic [31:0] er, input logic ee, input int lat, input bit push);
    resp_t r;
    @(posedge clk);
    #1;
    cur_addr  = a;
    cur_wdata = wd;
    cur_we    = w;
    cpu_req   = 1'b1;
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_we    = w;
    @(negedge clk);
    check("gnt", {31'b0, cpu_gnt}, 32'd1);
    if (push) begin
      r.rdata = er;
      r.err   = ee;
      r.cyc   = cyc + lat;
      sb.push_back(r);
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check({name, "_drained"}, sb.size(), 32'd0);
  endtask

  task automatic run_txn(input string name, input logic [31:0] a, input logic [31:0] wd,
                         input logic w, input logic [31:0] er, input logic ee, input int lat,
                         input int exp_tmr, input int exp_uart);
    int t0, u0, b0;
    t0 = tmr_req_cnt;
    u0 = uart_req_cnt;
    b0 = bus_bad;
    issue(a, wd, w, er, ee, lat, 1'b1);
    drain(name);
    check({name, "_tmr_req_cycles"}, tmr_req_cnt - t0, exp_tmr);
    check({name, "_uart_req_cycles"}, uart_req_cnt - u0, exp_uart);
    check({name, "_slave_bus"}, bus_bad - b0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, u0, g;
    rst_n      = 1'b1;
    cpu_req    = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    cpu_we     = 1'b0;
    tmr_rdata  = '0;
    tmr_ready  = 1'b1;
    uart_rdata = '0;
    uart_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_err", {31'b0, cpu_err}, 32'd0);
    check("rst_tmr_req", {31'b0, tmr_req}, 32'd0);
    check("rst_uart_req", {31'b0, uart_req}, 32'd0);
    check("rst_tmr_addr", tmr_addr, 32'd0);
    check("rst_gnt", {31'b0, cpu_gnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    tmr_rdata = 32'h0000_1234;
    run_txn("tmr_read", 32'h0200_BFF8, 32'h0, 1'b0, 32'h0000_1234, 1'b0, 2, 1, 0);
    tmr_rdata = 32'hDEAD_BEEF;
    run_txn("tmr_write", 32'h0200_4000, 32'h0000_0100, 1'b1, 32'h0, 1'b0, 2, 1, 0);
    run_txn("unmapped", 32'h3000_0000, 32'h0, 1'b0, 32'h0, 1'b1, 1, 0, 0);
    run_txn("misaligned", 32'h1000_0002, 32'h0, 1'b0, 32'h0, 1'b1, 1, 0, 0);
    uart_rdata = 32'hA5A5_5A5A;
    run_txn("uart_read_top", 32'h1000_0FFC, 32'h0, 1'b0, 32'hA5A5_5A5A, 1'b0, 2, 0, 1);
    run_txn("uart_write", 32'h1000_0004, 32'h0000_00C3, 1'b1, 32'h0, 1'b0, 2, 0, 1);
    tmr_rdata = 32'h0BAD_F00D;
    run_txn("tmr_read_top", 32'h0200_FFFC, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b0, 2, 1, 0);
    run_txn("past_tmr", 32'h0201_0000, 32'h0, 1'b0, 32'h0, 1'b1, 1, 0, 0);
    run_txn("below_tmr", 32'h01FF_FFFC, 32'h0, 1'b0, 32'h0, 1'b1, 1, 0, 0);
    run_txn("past_uart", 32'h1000_1000, 32'h0, 1'b0, 32'h0, 1'b1, 1, 0, 0);

    // UART never ready: 16 request cycles, error response one cycle later,
    // and a request re-raised during ACCESS must not be granted.
    uart_ready = 1'b0;
    t0 = uart_req_cnt;
    u0 = tmr_req_cnt;
    issue(32'h1000_0010, 32'h0, 1'b0, 32'h0, 1'b1, 17, 1'b1);
    cpu_req = 1'b1;
    g = 0;
    repeat (5) begin
      @(negedge clk);
      if (cpu_gnt) g++;
    end
    check("gnt_during_access", g, 32'd0);
    @(posedge clk);
    #1 cpu_req = 1'b0;
    drain("timeout");
    check("timeout_uart_req_cycles", uart_req_cnt - t0, 32'd16);
    check("timeout_tmr_req_cycles", tmr_req_cnt - u0, 32'd0);

    // Reset in the middle of a stalled UART access.
    issue(32'h1000_0020, 32'h0, 1'b0, 32'h0, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_rst_uart_req", {31'b0, uart_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_drops_uart_req", {31'b0, uart_req}, 32'd0);
    check("rst_no_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    uart_ready = 1'b1;
    uart_rdata = 32'h0000_7E57;
    run_txn("after_rst", 32'h1000_0020, 32'h0, 1'b0, 32'h0000_7E57, 1'b0, 2, 0, 1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/periph_bus_bridge.md
PERIPH_BUS_BRIDGE -- requirements
Module: periph_bus_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max cycles a slave may withhold ready.
REQ-002 SHALL have ports: clk  in  1  system clock, all logic on posedge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have CPU ports: cpu_req in 1; cpu_addr in 32; cpu_wdata in 32; cpu_we in 1; cpu_gnt out 1 (request accepted); cpu_rvalid out 1 (response pulse); cpu_rdata out 32; cpu_err out 1 (valid with cpu_rvalid).
REQ-005 SHALL have timer slave ports: tmr_req out 1; tmr_addr out 32; tmr_wdata out 32; tmr_we out 1; tmr_rdata in 32; tmr_ready in 1.
REQ-006 SHALL have UART slave ports: uart_req, uart_addr, uart_wdata, uart_we, uart_rdata, uart_ready, widths and meanings as timer.

Function
REQ-007 SHALL decode: timer region 0x0200_0000-0x0200_FFFF; UART region 0x1000_0000-0x1000_0FFF; everything else unmapped.
REQ-008 SHALL implement FSM states IDLE, ACCESS, RESP; one outstanding transaction only.
REQ-009 IDLE: cpu_gnt = cpu_req (combinational); on grant, SHALL latch addr, wdata, we, target select.
REQ-010 IDLE with grant to mapped, word-aligned address -> ACCESS next cycle.
REQ-011 IDLE with grant to unmapped address or cpu_addr[1:0] != 0 -> RESP next cycle with err=1, rdata=0, no slave req issued.
REQ-012 ACCESS: SHALL drive selected slave req=1 with latched addr/wdata/we; non-selected slave req=0; cpu_gnt=0.
REQ-013 ACCESS with selected ready=1 -> RESP next cycle; SHALL capture slave rdata for reads, 0 for writes; err=0.
REQ-014 ACCESS: timeout counter SHALL increment each cycle ready=0; at TIMEOUT_CYCLES cycles without ready -> RESP with err=1, rdata=0, slave req dropped.
REQ-015 RESP: cpu_rvalid=1 for exactly one cycle with registered cpu_rdata/cpu_err; cpu_gnt=0; next state IDLE.
REQ-016 Latency: mapped access with zero-wait slave: grant cycle N, slave req cycle N+1, cpu_rvalid cycle N+2.
REQ-017 Unmapped/misaligned: grant cycle N, cpu_rvalid cycle N+1.
REQ-018 cpu_req asserted in ACCESS/RESP SHALL be ignored (not granted); CPU holds request until granted.
REQ-019 Slave req SHALL be asserted only in ACCESS; slave outputs addr/wdata/we SHALL be stable throughout ACCESS.
REQ-020 Timeout counter SHALL clear on entry to ACCESS; width ceil(log2(TIMEOUT_CYCLES+1)), no wrap.
REQ-021 cpu_rdata/cpu_err SHALL hold last value outside RESP; only cpu_rvalid qualifies them.

Reset
REQ-022 On rst_n low: state IDLE, counter 0, latched regs 0, cpu_rvalid 0, cpu_rdata 0, cpu_err 0, all slave req 0.
REQ-023 Reset asserted mid-ACCESS SHALL drop slave req immediately (async) with no response issued to CPU.

Structure
REQ-024 Package periph_bus_pkg SHALL hold region base/mask constants, bridge state enum, slave-select enum, default TIMEOUT_CYCLES.
REQ-025 Address decode SHALL be a sub-module periph_addr_decode (combinational addr -> select + aligned flag), reused by future bridges.

Verification
REQ-026 Read 0x0200BFF8 with zero-wait timer, tmr_rdata=0x0000_1234 -> tmr_req high one cycle, cpu_rvalid at N+2, cpu_rdata=0x0000_1234, err=0.
REQ-027 Write 0x02004000 wdata=0x0000_0100 -> tmr_we=1, tmr_wdata=0x100 in ACCESS; rvalid N+2, rdata=0, err=0.
REQ-028 Read 0x3000_0000 -> no tmr_req/uart_req, rvalid N+1, err=1, rdata=0.
REQ-029 Read 0x1000_0002 (misaligned) -> no slave req, rvalid N+1, err=1.
REQ-030 UART read, uart_ready held 0 -> uart_req high 16 cycles, then dropped; rvalid next cycle, err=1, rdata=0.
REQ-031 rst_n low during ACCESS with uart_ready=0 -> uart_req falls immediately, no rvalid; after release, next request completes normally.
